// File: rtl/seq101_rr_sched_if.sv
// Bus interface for seq101_rr_sched: per-channel request/data/clear in, grant and match reporting out.
interface seq101_rr_sched_if #(
  parameter int NCH  = 4,
  parameter int CW   = 2,
  parameter int CNTW = 16
);
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  inp;
  logic [NCH-1:0]  clr;
  logic [NCH-1:0]  gnt;
  logic            det;
  logic [CW-1:0]   det_ch;
  logic [CNTW-1:0] match_cnt;
  logic            busy;

  modport master (
    output req, inp, clr,
    input  gnt, det, det_ch, match_cnt, busy
  );

  modport slave (
    input  req, inp, clr,
    output gnt, det, det_ch, match_cnt, busy
  );
endinterface

// File: rtl/seq101_rr_sched.sv
// Round-robin shared "101" Mealy detector over NCH serial channels with a per-channel state table.
// Define SEQ101_OVERLAP_EN for overlapping detection (match returns to S1 instead of S0).
module seq101_rr_sched #(
  parameter int NCH  = 4,
  parameter int CW   = 2,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  seq101_rr_sched_if.slave bus
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;

  logic [1:0]      state_q [NCH];
  logic [1:0]      state_d [NCH];
  logic [CW-1:0]   ptr_q, ptr_d;
  logic            det_q, det_d;
  logic [CW-1:0]   det_ch_q, det_ch_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  gnt;
  logic            found;
  logic [CW-1:0]   gidx;
  logic [1:0]      cur_st;
  logic [1:0]      nxt_st;
  logic            bit_in;
  logic            match;
  int              idx;

  assign elig = bus.req & ~bus.clr;

  // Search from the pointer, wrapping modulo NCH; grants are suppressed during reset.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = CW'(idx);
      end
    end
    if (!rst) found = 1'b0;
    if (found) gnt[gidx] = 1'b1;
  end

  always_comb begin
    cur_st = state_q[gidx];
    bit_in = bus.inp[gidx];
    match  = 1'b0;
    nxt_st = cur_st;
    case (cur_st)
      S0:      nxt_st = bit_in ? S1 : S0;
      S1:      nxt_st = bit_in ? S1 : S2;
      S2: begin
        if (bit_in) begin
          match = found;
`ifdef SEQ101_OVERLAP_EN
          nxt_st = S1;
`else
          nxt_st = S0;
`endif
        end else begin
          nxt_st = S0;
        end
      end
      default: nxt_st = S0;
    endcase
  end

  // Clear wins over nothing else: a cleared channel is never the granted one.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      if (bus.clr[i])
        state_d[i] = S0;
      else if (found && gidx == CW'(i))
        state_d[i] = nxt_st;
    end
    ptr_d    = ptr_q;
    if (found) ptr_d = (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
    det_d    = match;
    det_ch_d = match ? gidx : det_ch_q;
    cnt_d    = (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= S0;
      ptr_q    <= '0;
      det_q    <= 1'b0;
      det_ch_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
      ptr_q    <= ptr_d;
      det_q    <= det_d;
      det_ch_q <= det_ch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.busy      = |gnt;
  assign bus.det       = det_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq101_rr_sched.sv
// Randomized and directed bench for seq101_rr_sched against a bit-history reference model.
module tb_seq101_rr_sched;
  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int CNTW = 3;
  localparam int MAXC = (1 << CNTW) - 1;
`ifdef SEQ101_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   errors = 0;

  seq101_rr_sched_if #(.NCH(NCH), .CW(CW), .CNTW(CNTW)) bus ();

  seq101_rr_sched #(.NCH(NCH), .CW(CW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: per channel, the last three consumed bits and how many bits count toward the next match.
  int             seg   [NCH];
  logic [2:0]     last3 [NCH];
  int             mptr;
  int             mcnt;
  logic           mdet;
  int             mdetch;
  logic           pRst;
  logic [NCH-1:0] pInp, pClr;
  int             pG;
  logic [NCH-1:0] expGnt;
  bit             modelValid = 1'b0;
  int             detCount;
  int             lastDetCh;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    if (!pRst) begin
      for (int i = 0; i < NCH; i++) begin seg[i] = 0; last3[i] = 3'b000; end
      mptr = 0; mcnt = 0; mdet = 1'b0; mdetch = 0;
    end else begin
      mdet = 1'b0;
      if (pG >= 0) begin
        last3[pG] = {last3[pG][1:0], pInp[pG]};
        seg[pG]++;
        if (seg[pG] >= 3 && last3[pG] == 3'b101) begin
          mdet = 1'b1;
          mdetch = pG;
          if (mcnt < MAXC) mcnt++;
          if (!OVL) begin seg[pG] = 0; last3[pG] = 3'b000; end
        end
        mptr = (pG + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++)
        if (pClr[i]) begin seg[i] = 0; last3[i] = 3'b000; end
    end
  endtask

  task automatic applyStimulus(input logic rstv, input logic [NCH-1:0] r, input logic [NCH-1:0] d,
                               input logic [NCH-1:0] c);
    int j;
    @(posedge clk);
    #2;
    modelStep();
    rst = rstv; bus.req = r; bus.inp = d; bus.clr = c;
    pRst = rstv; pInp = d; pClr = c; pG = -1;
    if (rstv) begin
      for (int k = 0; k < NCH; k++) begin
        j = (mptr + k) % NCH;
        if (pG < 0 && r[j] && !c[j]) pG = j;
      end
    end
    expGnt = (pG >= 0) ? NCH'(1 << pG) : '0;
    modelValid = 1'b1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'hF, 4'h0, 4'h0);
    detCount = 0;
  endtask

  task automatic settle();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
      checkOutput("busy", 32'(bus.busy), 32'(expGnt != '0));
      checkOutput("det", 32'(bus.det), 32'(mdet));
      if (mdet) checkOutput("det_ch", 32'(bus.det_ch), 32'(mdetch));
      checkOutput("match_cnt", 32'(bus.match_cnt), 32'(mcnt));
      if (bus.det === 1'b1) begin
        detCount++;
        lastDetCh = int'(bus.det_ch);
      end
    end
  end

  initial begin
    logic [NCH-1:0] bits;
    logic [NCH-1:0] rr;
    logic [NCH-1:0] ri;
    logic [NCH-1:0] rc;
    logic [NCH-1:0] gseq [5];
    pRst = 1'b0; pInp = '0; pClr = '0; pG = -1; expGnt = '0;
    detCount = 0; lastDetCh = 0;
    bus.req = '0; bus.inp = '0; bus.clr = '0;

    // Reset with all channels requesting.
    resetDut();
    #1;
    checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset_cnt", 32'(bus.match_cnt), 32'h0);
    applyStimulus(1'b1, 4'hF, 4'h0, 4'h0);
    #1;
    checkOutput("first_gnt", 32'(bus.gnt), 32'h1);
    settle();

    // Single channel 0: 0,1,0,1,1,0,1 -> two matches.
    resetDut();
    bits = 4'b0000;
    foreach (bits[k]) bits[k] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bits = {3'b000, ((7'b1011010 >> k) & 7'b1) != 7'b0};
      applyStimulus(1'b1, 4'b0001, bits, 4'h0);
    end
    settle();
    checkOutput("single_dets", 32'(detCount), 32'd2);
    checkOutput("single_cnt", 32'(bus.match_cnt), 32'd2);

    // Round robin; channel 2 gets 1,0,1, others get 0s.
    resetDut();
    for (int k = 0; k < 12; k++) begin
      bits = '0;
      if (k % 4 == 2) bits[2] = ((3'b101 >> (k / 4)) & 3'b1) != 3'b0;
      applyStimulus(1'b1, 4'hF, bits, 4'h0);
      #1;
      if (k < 5) gseq[k] = bus.gnt;
    end
    settle();
    checkOutput("rr_g0", 32'(gseq[0]), 32'h1);
    checkOutput("rr_g1", 32'(gseq[1]), 32'h2);
    checkOutput("rr_g2", 32'(gseq[2]), 32'h4);
    checkOutput("rr_g3", 32'(gseq[3]), 32'h8);
    checkOutput("rr_g4", 32'(gseq[4]), 32'h1);
    checkOutput("rr_dets", 32'(detCount), 32'd1);
    checkOutput("rr_det_ch", 32'(lastDetCh), 32'd2);

    // Overlap: channel 1 alone, 1,0,1,0,1.
    resetDut();
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 4'b0010, (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'h0);
    settle();
    checkOutput("overlap_dets", 32'(detCount), OVL ? 32'd2 : 32'd1);

    // clr on channel 3 after "10" kills the prefix.
    resetDut();
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'h0);
    applyStimulus(1'b1, 4'b1000, 4'b0000, 4'h0);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'b1000);
    #1;
    checkOutput("clr_no_gnt", 32'(bus.gnt), 32'h0);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'h0);
    settle();
    checkOutput("clr_dets", 32'(detCount), 32'd0);

    // Reset in place of clr.
    resetDut();
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'h0);
    applyStimulus(1'b1, 4'b1000, 4'b0000, 4'h0);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 4'h0);
    detCount = 0;
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'h0);
    settle();
    checkOutput("rst_dets", 32'(detCount), 32'd0);

    // Saturation: nine matches on channel 0, counter stops at 7.
    resetDut();
    for (int k = 0; k < 27; k++)
      applyStimulus(1'b1, 4'b0001, (k % 3 == 1) ? 4'b0000 : 4'b0001, 4'h0);
    settle();
    checkOutput("sat_dets", 32'(detCount), 32'd9);
    checkOutput("sat_cnt", 32'(bus.match_cnt), 32'd7);

    // Random traffic with occasional clears and resets.
    resetDut();
    for (int k = 0; k < 800; k++) begin
      rr = NCH'($urandom);
      ri = NCH'($urandom);
      rc = NCH'($urandom & $urandom & $urandom);
      applyStimulus(($urandom_range(0, 99) != 0), rr, ri, rc);
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/seq101_rr_sched.md
Name: seq101_rr_sched

Overview:
- Time-multiplexes one shared "101" Mealy detection datapath across NCH independent serial bit channels.
- Round-robin arbiter grants at most one channel per cycle.
- Per-channel detector state is held in a state table, so each stream is detected exactly as if it had a private seq101 detector.
- Sits between the serial channel front-ends and the event/statistics logic: reports which channel matched and a global match count.

Parameters:
- NCH, 4, number of serial channels (2..16).
- CW, 2, channel-index width; must satisfy 2**CW >= NCH.
- CNTW, 16, width of the global match counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- req  input  NCH  per-channel bit-valid; req[i]=1 means inp[i] holds a bit to consume.
- inp  input  NCH  per-channel serial data bit.
- clr  input  NCH  per-channel state clear; returns that channel's detector state to S0.
- gnt  output  NCH  one-hot grant, combinational from req/clr/pointer. The bit is consumed at the edge ending a cycle with gnt[i]=1.
- det  output  1  registered one-cycle pulse: the granted bit completed a match.
- det_ch  output  CW  registered index of the channel that matched; valid when det=1.
- match_cnt  output  CNTW  registered total of matches since reset, saturating.
- busy  output  1  combinational OR of eligible requests (any gnt asserted).

Behaviour:
- Reset (rst=0 at an edge):
  - All channel states go to S0 and the RR pointer goes to 0.
  - det=0, det_ch=0, match_cnt=0.
  - gnt is forced to 0 while rst=0.
- Eligibility:
  - Channel i is eligible when req[i]=1 and clr[i]=0.
  - A channel with clr[i]=1 is never granted that cycle. Its bit is not consumed; the source must hold req.
- Arbitration:
  - Search starts at index ptr and wraps modulo NCH; the first eligible channel gets gnt.
  - At the edge, if any grant was issued, ptr <= (granted index + 1) mod NCH. Otherwise ptr holds.
  - Wrap case: channel NCH-1 granted gives ptr=0.
- Per-channel Mealy states:
  - S0 = nothing matched; S1 = seen "1"; S2 = seen "10".
  - S0: bit 1 -> S1; bit 0 -> S0.
  - S1: bit 1 -> S1; bit 0 -> S2.
  - S2: bit 1 -> match, next state per the Optional Feature; bit 0 -> S0.
  - Only the granted channel's state updates. All other states hold.
- Outputs:
  - Match detection uses the granted channel's current state plus its inp bit (Mealy).
  - det and det_ch are registered from that result, so they appear one cycle after the consuming edge.
  - det=0 in any cycle following a no-grant cycle.
- clr:
  - clr[i]=1 sets state[i] <= S0 at the edge.
  - clr is independent of the grant: other channels may be granted the same cycle.
  - A clr on a channel does not affect an already-registered det from that channel.
- match_cnt:
  - Increments by 1 on each match.
  - Holds at all-ones (2**CNTW - 1) once reached; never wraps.
- Reset mid-stream: all partial matches are lost. A "10" prefix sent before reset plus a "1" after reset gives no det.
- Throughput: one bit per cycle in aggregate. A lone requester is granted every cycle.

Optional Feature:
- Macro: SEQ101_OVERLAP_EN.
- Defined (overlapping): after a match in S2 on bit 1, next state = S1. Stream 1,0,1,0,1 yields 2 matches.
- Undefined (non-overlapping): after a match, next state = S0. Stream 1,0,1,0,1 yields 1 match.

Test Plan:
- Reset: rst=0 for 2 cycles with req=4'hF -> gnt=0, det=0, match_cnt=0. After release, first gnt=4'b0001.
- Single channel: req=4'b0001, inp[0] over cycles = 0,1,0,1,1,0,1 -> det pulses with det_ch=0 one cycle after the 4th bit (4th bit = first completed 1-0-1) and one cycle after the 7th bit; match_cnt=2.
- Round robin with interleaving:
  - req=4'hF held; gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Channel 2 fed bits 1,0,1 on its grants -> a single det with det_ch=2; other channels fed 0s give no det.
  - Check each channel's state is unaffected by the others' bits.
- Overlap: channel 1 alone, bits 1,0,1,0,1 -> 2 dets with SEQ101_OVERLAP_EN defined, 1 det without.
- clr and mid-stream reset:
  - Channel 3 fed 1,0, then clr[3]=1 with req[3]=1 -> no gnt[3] that cycle.
  - Next bit 1 on a later grant -> no det.
  - Repeat with a rst pulse in place of clr -> no det.
- Saturation: with CNTW=3, drive 9 matches -> match_cnt reads 1..7 and stays 7; det still pulses for matches 8 and 9.
